vga_clkgen_nco: RTL and testbench
=================================

Name: vga_clkgen_nco

Overview:
- Parametrised multi-channel clock-enable generator for the VGA/video path. Successor to the fixed two-output pixel-clock PLL wrapper.
- Derives NUM_CH pixel-rate clock enables and square-wave phase references from the single reference clock, using per-channel phase accumulators (NCO).
- Increment and phase are runtime-reconfigurable through a valid/ready config port, so modes (e.g. 25.175 MHz for 640x480) change without a new PLL.
- Provides a lock indication after a programmable settle interval, like a PLL's locked output.

Parameters:
- NUM_CH, 2, number of output channels (>=1).
- ACC_W, 32, accumulator/increment/phase width in bits (>=4).
- LOCK_CYCLES, 16, refclk cycles in SETTLE before locked asserts (>=1).
- INIT_INC, 2162571353, reset increment for all channels. With ACC_W=32 and a 50 MHz refclk this gives ~25.1756 MHz.
- INIT_PHASE_STEP, 2147483648, reset phase of channel k = k*INIT_PHASE_STEP mod 2^ACC_W. The default gives 180 deg between ch0 and ch1.

Ports:
- refclk  in  1  reference clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  config request valid.
- cfg_ready  out  1  config port can accept.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel.
- cfg_inc  in  ACC_W  new increment.
- cfg_phase  in  ACC_W  new phase (accumulator load value).
- cfg_err  out  1  one-cycle pulse when cfg_ch >= NUM_CH.
- clk_en  out  NUM_CH  per-channel one-cycle enable pulses.
- outclk  out  NUM_CH  per-channel square wave (accumulator MSB).
- locked  out  1  outputs stable at the configured rate.

Behaviour:
- Reset (async, immediate, any state):
  - acc[k]=phase[k]=k*INIT_PHASE_STEP mod 2^ACC_W; inc[k]=INIT_INC.
  - clk_en=0, outclk=0, locked=0, cfg_ready=0, cfg_err=0, settle counter=0, state=RST.
- Accumulators:
  - Every refclk edge with rst low, in every state: {carry,acc[k]} <= acc[k]+inc[k], computed at ACC_W+1 bits.
  - clk_en[k] <= carry and outclk[k] <= next acc[k][ACC_W-1], both registered on the same edge.
  - Enable rate = inc/2^ACC_W * f_refclk.
  - inc=0: channel frozen; clk_en[k] stays 0 and outclk[k] holds.
  - outclk duty is meaningful only for inc <= 2^(ACC_W-1). clk_en is valid for any inc.
  - Wrap-around is modulo 2^ACC_W, with no saturation.
- FSM:
  - RST: first edge after reset release -> SETTLE. cfg_ready=0.
  - SETTLE: cfg_ready=1. Counter increments each edge. When counter == LOCK_CYCLES-1 -> LOCKED and locked<=1 on that edge. A valid config accept -> APPLY.
  - LOCKED: cfg_ready=1, locked=1. A valid config accept -> APPLY, with locked<=0 on the accept edge.
  - APPLY: exactly one cycle, cfg_ready=0.
    - acc[ch]<=phase[ch]<=captured cfg_phase; inc[ch]<=captured cfg_inc. The load replaces the add for that channel this cycle.
    - Other channels keep free-running.
    - Counter<=0 -> SETTLE.
- Handshake:
  - Transfer occurs when cfg_valid && cfg_ready at an edge; cfg_ch, cfg_inc and cfg_phase are captured on that edge.
  - cfg_valid with cfg_ready=0 is held off, not dropped.
  - Invalid channel (cfg_ch >= NUM_CH): the transfer completes and cfg_err pulses 1 cycle. No state change, locked unaffected, counter unaffected.
- Accept in SETTLE restarts the settle interval via APPLY.
- Counter width: $clog2(LOCK_CYCLES+1).

Optional Feature:
- Macro: CLKGEN_REALIGN_EN.
- Defined: in APPLY, every channel reloads acc[j]<=phase[j]; the target channel uses its new phase. Relative phases are therefore exact after any reconfig.
- Undefined: only the target channel is reloaded; other channels free-run.

Test Plan:
- Bench parameters for all scenarios: NUM_CH=2, ACC_W=8, LOCK_CYCLES=4, INIT_INC=64, INIT_PHASE_STEP=128.
- 1. Release rst -> clk_en[0] pulses every 4 cycles; outclk[0] pattern 0,0,1,1 repeating. clk_en[1] pulses 2 cycles offset from clk_en[0]. locked rises on the 5th edge after release.
- 2. In LOCKED, write cfg_ch=0, cfg_inc=32, cfg_phase=0 -> cfg_ready low 1 cycle; locked 0 from the accept edge; clk_en[0] period 8. locked returns 4 cycles after APPLY. With CLKGEN_REALIGN_EN, ch1 acc=128 on the APPLY edge.
- 3. cfg_ch=1 (valid) then cfg_ch=3 on a NUM_CH=3 build -> cfg_err pulses exactly 1 cycle; locked stays 1; clk_en unchanged.
- 4. Write cfg_inc=0 to ch1 -> clk_en[1] never pulses; outclk[1] frozen at cfg_phase[7]; ch0 unaffected.
- 5. Assert rst mid-SETTLE, asynchronously between edges -> all outputs 0 immediately, before the next edge. Release -> scenario 1 sequence repeats exactly.
- 6. Hold cfg_valid=1 while in APPLY -> no transfer that cycle; the request is accepted on the first SETTLE edge, giving back-to-back APPLY/SETTLE/APPLY.

Source files
------------

// File: rtl/vga_clkgen_nco.sv
// vga_clkgen_nco: multi-channel NCO clock-enable generator for the video path.
// Each channel runs a phase accumulator; its carry is a one-cycle clock enable
// and its MSB a square-wave phase reference. Increment/phase are reloaded
// through a valid/ready config port; locked asserts after a settle interval.
// Optional build macro CLKGEN_REALIGN_EN: every channel is reloaded from its
// stored phase on each reconfiguration, keeping relative phases exact.
module vga_clkgen_nco #(
  parameter int unsigned     NUM_CH          = 2,
  parameter int unsigned     ACC_W           = 32,
  parameter int unsigned     LOCK_CYCLES     = 16,
  parameter longint unsigned INIT_INC        = 64'd2162571353,
  parameter longint unsigned INIT_PHASE_STEP = 64'd2147483648,
  localparam int unsigned    CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] outclk,
  output logic              locked
);

  localparam int unsigned CNT_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RST,
    ST_SETTLE,
    ST_LOCKED,
    ST_APPLY
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               locked_nxt, cfg_ready_nxt, cfg_err_nxt;
  logic               cap_en;
  logic [CH_W-1:0]    cap_ch;
  logic [ACC_W-1:0]   cap_inc, cap_phase;

  logic [ACC_W-1:0]   acc       [NUM_CH];
  logic [ACC_W-1:0]   phase     [NUM_CH];
  logic [ACC_W-1:0]   inc       [NUM_CH];
  logic [ACC_W-1:0]   acc_nxt   [NUM_CH];
  logic [ACC_W-1:0]   phase_nxt [NUM_CH];
  logic [ACC_W-1:0]   inc_nxt   [NUM_CH];
  logic [NUM_CH-1:0]  clk_en_nxt;

  logic               xfer_c;
  logic               ch_ok_c;

  assign xfer_c  = cfg_valid && cfg_ready;
  assign ch_ok_c = 32'(cfg_ch) < NUM_CH;

  // Control FSM: next state, settle counter, handshake and status outputs.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    locked_nxt  = locked;
    cfg_err_nxt = 1'b0;
    cap_en      = 1'b0;
    unique case (state)
      ST_RST: begin
        state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
          state_nxt  = ST_LOCKED;
          locked_nxt = 1'b1;
        end
        if (xfer_c) begin
          if (ch_ok_c) begin
            state_nxt  = ST_APPLY;
            locked_nxt = 1'b0;
            cap_en     = 1'b1;
          end else begin
            cfg_err_nxt = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (xfer_c) begin
          if (ch_ok_c) begin
            state_nxt  = ST_APPLY;
            locked_nxt = 1'b0;
            cap_en     = 1'b1;
          end else begin
            cfg_err_nxt = 1'b1;
          end
        end
      end
      ST_APPLY: begin
        cnt_nxt   = '0;
        state_nxt = ST_SETTLE;
      end
      default: begin
        state_nxt = ST_RST;
      end
    endcase
    cfg_ready_nxt = (state_nxt == ST_SETTLE) || (state_nxt == ST_LOCKED);
  end

  // Control registers and captured config request.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= ST_RST;
      cnt       <= '0;
      locked    <= 1'b0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      cap_ch    <= '0;
      cap_inc   <= '0;
      cap_phase <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      locked    <= locked_nxt;
      cfg_ready <= cfg_ready_nxt;
      cfg_err   <= cfg_err_nxt;
      if (cap_en) begin
        cap_ch    <= cfg_ch;
        cap_inc   <= cfg_inc;
        cap_phase <= cfg_phase;
      end
    end
  end

  // Accumulator update: free-running add, replaced by a load during APPLY.
  always_comb begin
    clk_en_nxt = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      {clk_en_nxt[k], acc_nxt[k]} = {1'b0, acc[k]} + {1'b0, inc[k]};
      phase_nxt[k] = phase[k];
      inc_nxt[k]   = inc[k];
      if (state == ST_APPLY) begin
`ifdef CLKGEN_REALIGN_EN
        acc_nxt[k]    = phase[k];
        clk_en_nxt[k] = 1'b0;
`endif
        if (32'(cap_ch) == k) begin
          acc_nxt[k]    = cap_phase;
          phase_nxt[k]  = cap_phase;
          inc_nxt[k]    = cap_inc;
          clk_en_nxt[k] = 1'b0;
        end
      end
    end
  end

  // Per-channel state plus registered enable and square-wave outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        acc[k]   <= ACC_W'(64'(k) * INIT_PHASE_STEP);
        phase[k] <= ACC_W'(64'(k) * INIT_PHASE_STEP);
        inc[k]   <= ACC_W'(INIT_INC);
      end
      clk_en <= '0;
      outclk <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        acc[k]    <= acc_nxt[k];
        phase[k]  <= phase_nxt[k];
        inc[k]    <= inc_nxt[k];
        outclk[k] <= acc_nxt[k][ACC_W-1];
      end
      clk_en <= clk_en_nxt;
    end
  end

endmodule

// File: tb/tb_vga_clkgen_nco.sv
// Directed self-checking bench for vga_clkgen_nco (NUM_CH=2, ACC_W=8,
// LOCK_CYCLES=4, INIT_INC=64, INIT_PHASE_STEP=128) plus a NUM_CH=3 instance
// used for the out-of-range channel cases.
module tb_vga_clkgen_nco;

  logic       refclk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [0:0] cfg_ch;
  logic [7:0] cfg_inc;
  logic [7:0] cfg_phase;
  logic       cfg_err;
  logic [1:0] clk_en;
  logic [1:0] outclk;
  logic       locked;

  logic       c3_valid;
  logic       c3_ready;
  logic [1:0] c3_ch;
  logic [7:0] c3_inc;
  logic [7:0] c3_phase;
  logic       c3_err;
  logic [2:0] c3_en;
  logic [2:0] c3_out;
  logic       c3_locked;

  int n_chk;
  int n_fail;
  int cyc;

  vga_clkgen_nco #(
    .NUM_CH(2), .ACC_W(8), .LOCK_CYCLES(4),
    .INIT_INC(64'd64), .INIT_PHASE_STEP(64'd128)
  ) dut (
    .refclk(refclk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_inc(cfg_inc), .cfg_phase(cfg_phase), .cfg_err(cfg_err),
    .clk_en(clk_en), .outclk(outclk), .locked(locked)
  );

  vga_clkgen_nco #(
    .NUM_CH(3), .ACC_W(8), .LOCK_CYCLES(4),
    .INIT_INC(64'd64), .INIT_PHASE_STEP(64'd128)
  ) dut3 (
    .refclk(refclk), .rst(rst),
    .cfg_valid(c3_valid), .cfg_ready(c3_ready), .cfg_ch(c3_ch),
    .cfg_inc(c3_inc), .cfg_phase(c3_phase), .cfg_err(c3_err),
    .clk_en(c3_en), .outclk(c3_out), .locked(c3_locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Edges since reset release.
  always @(posedge refclk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge refclk);
    n_chk++;
    if ({clk_en, outclk, locked, cfg_ready, cfg_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b",
               {clk_en, outclk, locked, cfg_ready, cfg_err}, 7'b0);
    end
    n_chk++;
    if ({c3_en, c3_out, c3_locked, c3_ready, c3_err} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs3: got %b expected %b",
               {c3_en, c3_out, c3_locked, c3_ready, c3_err}, 9'b0);
    end
  endtask

  // Called at a negedge with rst high; releases it and checks edges 1..8.
  task automatic test_startup(input string tag);
    logic [1:0] en_t  [8];
    logic [1:0] out_t [8];
    logic [6:0] exp;
    en_t  = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    out_t = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10};
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge refclk);
      exp = {en_t[i], out_t[i], (i >= 4), 1'b1, 1'b0};
      n_chk++;
      if ({clk_en, outclk, locked, cfg_ready, cfg_err} !== exp) begin
        n_fail++;
        $display("FAIL %s edge%0d {en,out,lock,rdy,err}: got %b expected %b",
                 tag, i + 1, {clk_en, outclk, locked, cfg_ready, cfg_err}, exp);
      end
    end
  endtask

  task automatic test_reconfig();
    logic [2:0] exp;
    logic [1:0] exp_ch1;
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_inc = 8'd32; cfg_phase = 8'd0;
    @(negedge refclk);
    n_chk++;
    if ({cfg_ready, locked} !== 2'b00) begin
      n_fail++;
      $display("FAIL reconfig_accept {rdy,lock}: got %b expected 00", {cfg_ready, locked});
    end
    cfg_valid = 1'b0;
    @(negedge refclk);
`ifdef CLKGEN_REALIGN_EN
    exp_ch1 = 2'b01;
`else
    exp_ch1 = 2'b10;
`endif
    n_chk++;
    if ({cfg_ready, locked, clk_en[0], outclk[0], clk_en[1], outclk[1]} !== {4'b1000, exp_ch1}) begin
      n_fail++;
      $display("FAIL reconfig_apply {rdy,lock,en0,out0,en1,out1}: got %b expected %b",
               {cfg_ready, locked, clk_en[0], outclk[0], clk_en[1], outclk[1]}, {4'b1000, exp_ch1});
    end
    for (int m = 11; m <= 26; m++) begin
      @(negedge refclk);
      exp = {(m == 18 || m == 26), (((m - 10) % 8) >= 4), (m >= 14)};
      n_chk++;
      if ({clk_en[0], outclk[0], locked} !== exp) begin
        n_fail++;
        $display("FAIL reconfig_run edge%0d {en0,out0,lock}: got %b expected %b",
                 m, {clk_en[0], outclk[0], locked}, exp);
      end
    end
  endtask

  task automatic test_cfg_err();
    logic [2:0] exp_en;
    c3_valid = 1'b1; c3_ch = 2'd3; c3_inc = 8'h11; c3_phase = 8'h22;
    @(negedge refclk);
    c3_valid = 1'b0;
    exp_en = {(cyc % 4 == 0), (cyc % 4 == 2), (cyc % 4 == 0)};
    n_chk++;
    if ({c3_err, c3_locked, c3_ready, c3_en} !== {3'b111, exp_en}) begin
      n_fail++;
      $display("FAIL cfg_err_pulse {err,lock,rdy,en}: got %b expected %b",
               {c3_err, c3_locked, c3_ready, c3_en}, {3'b111, exp_en});
    end
    @(negedge refclk);
    exp_en = {(cyc % 4 == 0), (cyc % 4 == 2), (cyc % 4 == 0)};
    n_chk++;
    if ({c3_err, c3_locked, c3_ready, c3_en} !== {3'b011, exp_en}) begin
      n_fail++;
      $display("FAIL cfg_err_clear {err,lock,rdy,en}: got %b expected %b",
               {c3_err, c3_locked, c3_ready, c3_en}, {3'b011, exp_en});
    end
    c3_valid = 1'b1; c3_ch = 2'd1; c3_inc = 8'd64; c3_phase = 8'd0;
    @(negedge refclk);
    c3_valid = 1'b0;
    n_chk++;
    if ({c3_err, c3_locked, c3_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL cfg_valid_ch {err,lock,rdy}: got %b expected 000", {c3_err, c3_locked, c3_ready});
    end
    @(negedge refclk);
    c3_valid = 1'b1; c3_ch = 2'd3;
    @(negedge refclk);
    c3_valid = 1'b0;
    n_chk++;
    if ({c3_err, c3_locked, c3_ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL cfg_err_settle {err,lock,rdy}: got %b expected 101", {c3_err, c3_locked, c3_ready});
    end
    repeat (2) @(negedge refclk);
    n_chk++;
    if (c3_locked !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_err_early_lock: got %b expected 0", c3_locked);
    end
    @(negedge refclk);
    n_chk++;
    if (c3_locked !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_err_relock: got %b expected 1", c3_locked);
    end
  endtask

  task automatic test_inc_zero();
    int pulses;
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_inc = 8'd0; cfg_phase = 8'hA5;
    @(negedge refclk);
    cfg_valid = 1'b0;
    n_chk++;
    if ({cfg_ready, locked} !== 2'b00) begin
      n_fail++;
      $display("FAIL inc0_accept {rdy,lock}: got %b expected 00", {cfg_ready, locked});
    end
    @(negedge refclk);
    n_chk++;
    if ({clk_en[1], outclk[1]} !== 2'b01) begin
      n_fail++;
      $display("FAIL inc0_apply {en1,out1}: got %b expected 01", {clk_en[1], outclk[1]});
    end
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge refclk);
      if (clk_en[0] === 1'b1) pulses++;
      n_chk++;
      if ({clk_en[1], outclk[1]} !== 2'b01) begin
        n_fail++;
        $display("FAIL inc0_frozen cycle%0d {en1,out1}: got %b expected 01", i, {clk_en[1], outclk[1]});
      end
    end
    n_chk++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL inc0_ch0_pulses: got %0d expected 2", pulses);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] tail [4];
    tail = '{3'b010, 3'b100, 3'b010, 3'b101};
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_inc = 8'd64; cfg_phase = 8'd64;
    @(negedge refclk);
    n_chk++;
    if ({cfg_ready, locked} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_accept1 {rdy,lock}: got %b expected 00", {cfg_ready, locked});
    end
    cfg_inc = 8'd128; cfg_phase = 8'd0;
    @(negedge refclk);
    n_chk++;
    if ({cfg_ready, clk_en[0], outclk[0]} !== 3'b100) begin
      n_fail++;
      $display("FAIL b2b_apply1 {rdy,en0,out0}: got %b expected 100", {cfg_ready, clk_en[0], outclk[0]});
    end
    @(negedge refclk);
    cfg_valid = 1'b0;
    n_chk++;
    if ({cfg_ready, clk_en[0], outclk[0]} !== 3'b001) begin
      n_fail++;
      $display("FAIL b2b_accept2 {rdy,en0,out0}: got %b expected 001", {cfg_ready, clk_en[0], outclk[0]});
    end
    @(negedge refclk);
    n_chk++;
    if ({cfg_ready, clk_en[0], outclk[0]} !== 3'b100) begin
      n_fail++;
      $display("FAIL b2b_apply2 {rdy,en0,out0}: got %b expected 100", {cfg_ready, clk_en[0], outclk[0]});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge refclk);
      n_chk++;
      if ({clk_en[0], outclk[0], locked} !== tail[i]) begin
        n_fail++;
        $display("FAIL b2b_run%0d {en0,out0,lock}: got %b expected %b",
                 i, {clk_en[0], outclk[0], locked}, tail[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_inc = 8'd64; cfg_phase = 8'd0;
    @(negedge refclk);
    cfg_valid = 1'b0;
    repeat (2) @(negedge refclk);
    n_chk++;
    if ({cfg_ready, locked, outclk[1]} !== 3'b101) begin
      n_fail++;
      $display("FAIL async_pre {rdy,lock,out1}: got %b expected 101", {cfg_ready, locked, outclk[1]});
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({clk_en, outclk, locked, cfg_ready, cfg_err, c3_en, c3_out, c3_locked, c3_ready, c3_err} !== 16'b0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %b expected 0",
               {clk_en, outclk, locked, cfg_ready, cfg_err, c3_en, c3_out, c3_locked, c3_ready, c3_err});
    end
    @(negedge refclk);
    test_startup("restart");
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0; cfg_phase = '0;
    c3_valid = 1'b0;  c3_ch = '0;  c3_inc = '0;  c3_phase = '0;
    test_reset();
    test_startup("startup");
    test_reconfig();
    test_cfg_err();
    test_inc_zero();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
